// File: rtl/ray_dispatcher.sv
// ray_dispatcher -- walks an IMG_W x IMG_H image plane in raster order and
// issues one primary ray per pixel to a downstream intersect unit, keeping
// at most MAX_INFLIGHT rays outstanding. Hit results come back in issue
// order and are re-tagged with their pixel coordinates by a separate result
// counter before being strobed out on pix_*.
//
// Ports:
//   sysclk, rst_n       clock, synchronous active-low reset
//   start               one-cycle pulse, accepted only while idle
//   cam_orig            camera origin, latched at an accepted start
//   ray_valid/ray_ready ray handshake to the intersect unit
//   ray_orig, ray_dir   ray payload (vec3_t, signed integer fields)
//   hit_valid, hit_in   in-order hit results from the intersect unit
//   pix_valid, pix_x, pix_y, pix_hit   resolved pixel strobe, 1 cycle after hit
//   busy, frame_done    frame status
//   hit_count           hits in the current/last frame (0 unless HIT_COUNT_EN)
//   dbg_state           FSM state for observation
//
// Optional feature: define HIT_COUNT_EN to build the per-frame hit counter.
//
// Handshake: a ray transfers on a rising edge where ray_valid && ray_ready;
// once ray_valid is high, ray_orig/ray_dir stay stable until that transfer.
// hit_valid has no back-pressure; it is ignored when nothing is in flight.

package ray_dispatcher_pkg;
  localparam int COORD_W = 16;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vec3_t;

  localparam vec3_t VEC3_DEFAULT = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int IMG_W        = 16,
  parameter int IMG_H        = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int FOCAL        = 16
) (
  input  logic                               sysclk,
  input  logic                               rst_n,
  input  logic                               start,
  input  vec3_t                              cam_orig,
  output logic                               ray_valid,
  input  logic                               ray_ready,
  output vec3_t                              ray_orig,
  output vec3_t                              ray_dir,
  input  logic                               hit_valid,
  input  logic                               hit_in,
  output logic                               pix_valid,
  output logic [$clog2(IMG_W)-1:0]           pix_x,
  output logic [$clog2(IMG_H)-1:0]           pix_y,
  output logic                               pix_hit,
  output logic                               busy,
  output logic                               frame_done,
  output logic [$clog2(IMG_W*IMG_H):0]       hit_count,
  output logic [1:0]                         dbg_state
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int IFW = $clog2(MAX_INFLIGHT + 1);

  state_e          state_q, state_d;
  logic [XW-1:0]   ix_q, ix_d;        // issue pixel
  logic [YW-1:0]   iy_q, iy_d;
  logic [XW-1:0]   rx_q, rx_d;        // result pixel
  logic [YW-1:0]   ry_q, ry_d;
  logic [IFW-1:0]  infl_q, infl_d;
  vec3_t           orig_q, orig_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic            pix_hit_q, pix_hit_d;

  logic issue_last, res_last, ray_valid_c, xfer, hit_ok;

  always_comb begin
    state_d     = state_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    infl_d      = infl_q;
    orig_d      = orig_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_hit_d   = pix_hit_q;

    issue_last  = (ix_q == XW'(IMG_W - 1)) && (iy_q == YW'(IMG_H - 1));
    res_last    = (rx_q == XW'(IMG_W - 1)) && (ry_q == YW'(IMG_H - 1));
    ray_valid_c = (state_q == ST_ISSUE) && (infl_q < IFW'(MAX_INFLIGHT));
    xfer        = ray_valid_c && ray_ready;
    // A result with nothing outstanding cannot belong to this frame
    // (e.g. one arriving after a reset), so it is dropped.
    hit_ok      = hit_valid && (infl_q != '0);

    if (xfer) begin
      if (ix_q == XW'(IMG_W - 1)) begin
        ix_d = '0;
        iy_d = (iy_q == YW'(IMG_H - 1)) ? '0 : iy_q + YW'(1);
      end else begin
        ix_d = ix_q + XW'(1);
      end
    end

    if (hit_ok) begin
      pix_valid_d = 1'b1;
      pix_x_d     = rx_q;
      pix_y_d     = ry_q;
      pix_hit_d   = hit_in;
      if (rx_q == XW'(IMG_W - 1)) begin
        rx_d = '0;
        ry_d = (ry_q == YW'(IMG_H - 1)) ? '0 : ry_q + YW'(1);
      end else begin
        rx_d = rx_q + XW'(1);
      end
    end

    case ({xfer, hit_ok})
      2'b10:   infl_d = infl_q + IFW'(1);
      2'b01:   infl_d = infl_q - IFW'(1);
      default: infl_d = infl_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          ix_d    = '0;
          iy_d    = '0;
          rx_d    = '0;
          ry_d    = '0;
          orig_d  = cam_orig;
        end
      end
      ST_ISSUE: if (xfer && issue_last) state_d = ST_DRAIN;
      // The last result can only arrive after the last ray has gone out,
      // so completion is detected in DRAIN only.
      ST_DRAIN: if (hit_ok && res_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ix_q        <= '0;
      iy_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      infl_q      <= '0;
      orig_q      <= VEC3_DEFAULT;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      infl_q      <= infl_d;
      orig_q      <= orig_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_hit_q   <= pix_hit_d;
    end
  end

  // Direction is a pure function of the issue pixel, which only moves on a
  // transfer, so it is stable for as long as ray_valid is held.
  always_comb begin
    ray_dir = VEC3_DEFAULT;
    if (state_q == ST_ISSUE) begin
      ray_dir.x = COORD_W'(ix_q) - COORD_W'(IMG_W / 2);
      ray_dir.y = COORD_W'(IMG_H / 2) - COORD_W'(iy_q);
      ray_dir.z = '0 - COORD_W'(FOCAL);
    end
  end

  assign ray_valid  = ray_valid_c;
  assign ray_orig   = orig_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_hit    = pix_hit_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

`ifdef HIT_COUNT_EN
  logic [$clog2(IMG_W*IMG_H):0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (state_q == ST_IDLE && start) begin
      hit_cnt_d = '0;
    end else if (pix_valid_q && pix_hit_q) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x4 image, MAX_INFLIGHT=2, FOCAL=16.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. after the edge has settled.

module tb_ray_dispatcher;
  import ray_dispatcher_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int MAXF = 2;
`ifdef HIT_COUNT_EN
  localparam int EXP_HITS = 16;
`else
  localparam int EXP_HITS = 0;
`endif

  // clock / reset
  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        start = 1'b0;
  vec3_t       cam_orig = '0;
  logic        ray_valid;
  logic        ray_ready = 1'b0;
  vec3_t       ray_orig, ray_dir;
  logic        hit_valid = 1'b0;
  logic        hit_in = 1'b0;
  logic        pix_valid;
  logic [1:0]  pix_x, pix_y;
  logic        pix_hit, busy, frame_done;
  logic [4:0]  hit_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  ray_dispatcher #(.IMG_W(W), .IMG_H(H), .MAX_INFLIGHT(MAXF), .FOCAL(16)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .cam_orig(cam_orig),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_orig(ray_orig),
    .ray_dir(ray_dir), .hit_valid(hit_valid), .hit_in(hit_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_hit(pix_hit),
    .busy(busy), .frame_done(frame_done), .hit_count(hit_count),
    .dbg_state(dbg_state)
  );

  function automatic vec3_t exp_dir(input int idx);
    vec3_t v;
    v.x = 16'((idx % W) - W / 2);
    v.y = 16'(H / 2 - (idx / W));
    v.z = -16'sd16;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ray_ready = 1'b0; hit_valid = 1'b0; hit_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input vec3_t org);
    cam_orig = org;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (ray_valid !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || hit_count !== 5'd0) begin
      bad++;
      $display("FAIL %s ctrl: got rv=%b pv=%b busy=%b fd=%b hc=%0d want all 0",
               tag, ray_valid, pix_valid, busy, frame_done, hit_count);
    end
    total++;
    if (ray_orig !== VEC3_DEFAULT || ray_dir !== VEC3_DEFAULT) begin
      bad++;
      $display("FAIL %s vec: got orig=%h dir=%h want 0", tag, ray_orig, ray_dir);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_backpressure();
    vec3_t want;
    vec3_t org;
    org.x = 16'sd1; org.y = 16'sd2; org.z = 16'sd3;
    pulse_start(org);
    ray_ready = 1'b1;
    tick();                       // pixel (0,0) transfers
    ray_ready = 1'b0;
    want = exp_dir(1);            // (-1, 2, -16)
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ray_valid !== 1'b1 || ray_dir !== want) begin
        bad++;
        $display("FAIL backpressure c%0d: got rv=%b dir=%h want rv=1 dir=%h",
                 i, ray_valid, ray_dir, want);
      end
      tick();
    end
    total++;
    if (ray_orig !== org) begin
      bad++;
      $display("FAIL backpressure orig: got %h want %h", ray_orig, org);
    end
  endtask

  task automatic test_inflight_limit();
    int nx = 0;
    vec3_t org;
    org = '0;
    pulse_start(org);
    ray_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ray_valid && ray_ready) nx++;
      tick();
    end
    total++;
    if (nx != 2 || ray_valid !== 1'b0) begin
      bad++;
      $display("FAIL inflight_limit: got xfers=%0d rv=%b want 2 rv=0", nx, ray_valid);
    end
    // one result frees a slot
    hit_valid = 1'b1; hit_in = 1'b0;
    tick();
    total++;
    if (ray_valid !== 1'b1 || pix_valid !== 1'b1 || pix_x !== 2'd0 ||
        pix_y !== 2'd0 || pix_hit !== 1'b0 || ray_dir !== exp_dir(2)) begin
      bad++;
      $display("FAIL inflight_release: got rv=%b pv=%b px=%0d py=%0d ph=%b dir=%h",
               ray_valid, pix_valid, pix_x, pix_y, pix_hit, ray_dir);
    end
    // transfer and result in the same cycle with one in flight
    hit_in = 1'b1;
    tick();
    hit_valid = 1'b0;
    total++;
    if (ray_valid !== 1'b1 || ray_dir !== exp_dir(3) || pix_valid !== 1'b1 ||
        pix_x !== 2'd1 || pix_hit !== 1'b1) begin
      bad++;
      $display("FAIL simultaneous: got rv=%b dir=%h pv=%b px=%0d ph=%b want rv=1 dir=%h pv=1 px=1 ph=1",
               ray_valid, ray_dir, pix_valid, pix_x, pix_hit, exp_dir(3));
    end
  endtask

  // Full frame with a 3-cycle return pipe, every result a hit. Optionally
  // pulses start once the frame is draining.
  task automatic run_frame(input string tag, input bit start_in_drain);
    logic [2:0] sh = '0;
    int nxfer = 0, npix = 0, ndone = 0, errs = 0;
    bit injected = 0;
    vec3_t org;
    org.x = 16'sd5; org.y = -16'sd3; org.z = 16'sd7;
    pulse_start(org);
    ray_ready = 1'b1;
    hit_in = 1'b1;
    total++;
    if (hit_count !== 5'd0) begin
      bad++;
      $display("FAIL %s hc_clear: got %0d want 0", tag, hit_count);
    end
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (busy !== (ndone == 0)) errs++;
      if (frame_done) ndone++;
      if (pix_valid) begin
        if (pix_x !== 2'(npix % W) || pix_y !== 2'(npix / W) || pix_hit !== 1'b1) begin
          errs++;
          $display("FAIL %s pix%0d: got (%0d,%0d,%b) want (%0d,%0d,1)",
                   tag, npix, pix_x, pix_y, pix_hit, npix % W, npix / W);
        end
        npix++;
      end
      start = 1'b0;
      if (start_in_drain && !injected && dbg_state == 2'd2) begin
        start = 1'b1;
        injected = 1;
      end
      if (ray_valid) begin
        if (ray_dir !== exp_dir(nxfer) || ray_orig !== org) begin
          errs++;
          $display("FAIL %s ray%0d: got dir=%h orig=%h want dir=%h orig=%h",
                   tag, nxfer, ray_dir, ray_orig, exp_dir(nxfer), org);
        end
        nxfer++;
      end
      hit_valid = sh[2];
      sh = {sh[1:0], ray_valid};
      tick();
    end
    start = 1'b0; hit_valid = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s per_cycle: got %0d bad cycles want 0", tag, errs);
    end
    total++;
    if (nxfer != 16 || npix != 16 || ndone != 1) begin
      bad++;
      $display("FAIL %s counts: got xfer=%0d pix=%0d done=%0d want 16 16 1",
               tag, nxfer, npix, ndone);
    end
    total++;
    if (busy !== 1'b0 || hit_count !== 5'(EXP_HITS)) begin
      bad++;
      $display("FAIL %s end: got busy=%b hc=%0d want busy=0 hc=%0d",
               tag, busy, hit_count, EXP_HITS);
    end
    total++;
    if (start_in_drain && !injected) begin
      bad++;
      $display("FAIL %s drain_seen: got 0 want 1", tag);
    end
  endtask

  task automatic test_full_frame();
    run_frame("full_frame", 1'b0);
  endtask

  task automatic test_start_in_drain();
    run_frame("start_in_drain", 1'b1);
  endtask

  task automatic test_reset_midframe();
    logic [2:0] sh = '0;
    int nxfer = 0;
    vec3_t org;
    org.x = 16'sd9; org.y = 16'sd9; org.z = 16'sd9;
    pulse_start(org);
    ray_ready = 1'b1; hit_in = 1'b1;
    for (int cyc = 0; cyc < 60 && nxfer < 7; cyc++) begin
      if (ray_valid) nxfer++;
      hit_valid = sh[2];
      sh = {sh[1:0], ray_valid};
      tick();
    end
    total++;
    if (nxfer != 7 || ray_dir !== exp_dir(7)) begin
      bad++;
      $display("FAIL midframe_reach: got xfers=%0d dir=%h want 7 dir=%h",
               nxfer, ray_dir, exp_dir(7));
    end
    rst_n = 1'b0; hit_valid = 1'b0; ray_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midframe_reset");
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    total++;
    if (pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL late_hit: got pv=%b want 0", pix_valid);
    end
    tick();
    total++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || ray_valid !== 1'b0) begin
      bad++;
      $display("FAIL late_hit_after: got pv=%b busy=%b rv=%b want 0 0 0",
               pix_valid, busy, ray_valid);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    do_reset();
    test_inflight_limit();
    do_reset();
    test_full_frame();
    test_start_in_drain();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
